// File: rtl/matrix_input_sequencer.sv
// Parses an ASCII "m n e00 e01 ..." byte stream into row-major element writes and
// keeps a per-shape round-robin slot pointer so each new m x n matrix overwrites the oldest slot.
module matrix_input_sequencer #(
    parameter int MAX_DIM    = 5,
    parameter int MAX_STORE  = 2,
    parameter int ELEM_WIDTH = 8,
    localparam int SLOT_W    = (MAX_STORE > 1) ? $clog2(MAX_STORE) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_rx_valid,
    input  logic [7:0]            i_rx_data,
    output logic                  o_wr_en,
    output logic [SLOT_W-1:0]     o_wr_slot,
    output logic [2:0]            o_wr_row,
    output logic [2:0]            o_wr_col,
    output logic [ELEM_WIDTH-1:0] o_wr_data,
    output logic                  o_wr_commit,
    output logic [2:0]            o_dim_m,
    output logic [2:0]            o_dim_n,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [1:0]            o_err_code
);

    localparam int DIM_IDX_W = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
    localparam logic [1:0] ERR_BAD_DIM  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_M,
        S_GET_N,
        S_GET_ELEM,
        S_COMMIT
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SLOT_W-1:0]     r_slot_ptr [MAX_DIM][MAX_DIM];
    logic [2:0]            r_row;
    logic [2:0]            r_col;
    logic [2:0]            r_dim_m;
    logic [2:0]            r_dim_n;
    logic                  r_wr_en;
    logic [SLOT_W-1:0]     r_wr_slot;
    logic [2:0]            r_wr_row;
    logic [2:0]            r_wr_col;
    logic [ELEM_WIDTH-1:0] r_wr_data;
    logic                  r_commit;
    logic                  r_error;
    logic [1:0]            r_err_code;

    logic                  w_is_digit;
    logic                  w_is_sep;
    logic                  w_byte;
    logic [3:0]            w_digit;
    logic                  w_dim_ok;
    logic                  w_last_col;
    logic                  w_last_elem;
    logic [DIM_IDX_W-1:0]  w_m_idx;
    logic [DIM_IDX_W-1:0]  w_n_idx;
    logic [SLOT_W-1:0]     w_cur_ptr;
    logic [SLOT_W-1:0]     w_ptr_inc;

    logic                  w_arm;
    logic                  w_latch_m;
    logic                  w_latch_n;
    logic                  w_do_write;
    logic                  w_do_commit;
    logic                  w_do_error;
    logic [1:0]            w_err_kind;

    // Byte classification: a digit's value is simply its low nibble.
    assign w_is_digit = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);
    assign w_is_sep   = (i_rx_data == 8'h20) || (i_rx_data == 8'h0D) || (i_rx_data == 8'h0A);
    assign w_byte     = i_rx_valid && !w_is_sep;
    assign w_digit    = i_rx_data[3:0];
    assign w_dim_ok   = (w_digit != 4'd0) && (w_digit <= 4'(MAX_DIM));

    assign w_last_col  = (r_col == r_dim_n - 3'd1);
    assign w_last_elem = w_last_col && (r_row == r_dim_m - 3'd1);

    assign w_m_idx   = DIM_IDX_W'(r_dim_m - 3'd1);
    assign w_n_idx   = DIM_IDX_W'(r_dim_n - 3'd1);
    assign w_cur_ptr = r_slot_ptr[w_m_idx][w_n_idx];
    assign w_ptr_inc = (w_cur_ptr == SLOT_W'(MAX_STORE - 1)) ? '0 : w_cur_ptr + SLOT_W'(1);

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_state_next = r_state;
        w_arm        = 1'b0;
        w_latch_m    = 1'b0;
        w_latch_n    = 1'b0;
        w_do_write   = 1'b0;
        w_do_commit  = 1'b0;
        w_do_error   = 1'b0;
        w_err_kind   = ERR_NONE;

        if (i_abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_arm        = 1'b1;
                        w_state_next = S_GET_M;
                    end
                end
                S_GET_M, S_GET_N: begin
                    if (w_byte) begin
                        if (!w_is_digit) begin
                            w_do_error = 1'b1;
                            w_err_kind = ERR_BAD_CHAR;
                        end else if (!w_dim_ok) begin
                            w_do_error = 1'b1;
                            w_err_kind = ERR_BAD_DIM;
                        end else if (r_state == S_GET_M) begin
                            w_latch_m    = 1'b1;
                            w_state_next = S_GET_N;
                        end else begin
                            w_latch_n    = 1'b1;
                            w_state_next = S_GET_ELEM;
                        end
                    end
                end
                S_GET_ELEM: begin
                    if (w_byte) begin
                        if (!w_is_digit) begin
                            w_do_error = 1'b1;
                            w_err_kind = ERR_BAD_CHAR;
                        end else begin
                            w_do_write = 1'b1;
                            if (w_last_elem) begin
                                w_state_next = S_COMMIT;
                            end
                        end
                    end
                end
                S_COMMIT: begin
                    w_do_commit  = 1'b1;
                    w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase

            if (w_do_error) begin
                w_state_next = S_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_dim_m    <= '0;
            r_dim_n    <= '0;
            r_wr_en    <= 1'b0;
            r_wr_slot  <= '0;
            r_wr_row   <= '0;
            r_wr_col   <= '0;
            r_wr_data  <= '0;
            r_commit   <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            // NOTE: the pointer table is flops, not RAM, and must read as all-zero after reset,
            // so it is cleared here along with the rest of the state.
            for (int i = 0; i < MAX_DIM; i++) begin
                for (int j = 0; j < MAX_DIM; j++) begin
                    r_slot_ptr[i][j] <= '0;
                end
            end
        end else begin
            r_state  <= w_state_next;
            r_wr_en  <= w_do_write;
            r_commit <= w_do_commit;
            r_error  <= w_do_error;

            if (w_arm) begin
                r_row      <= '0;
                r_col      <= '0;
                r_err_code <= ERR_NONE;
            end
            if (w_do_error) begin
                r_err_code <= w_err_kind;
            end
            if (w_latch_m) begin
                r_dim_m <= w_digit[2:0];
            end
            if (w_latch_n) begin
                r_dim_n <= w_digit[2:0];
            end

            if (w_do_write) begin
                r_wr_row  <= r_row;
                r_wr_col  <= r_col;
                r_wr_data <= ELEM_WIDTH'(w_digit);
                r_wr_slot <= w_cur_ptr;
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + 3'd1;
                end else begin
                    r_col <= r_col + 3'd1;
                end
            end

            // The committed slot is shown on wr_slot while its pointer moves on.
            if (w_do_commit) begin
                r_wr_slot                  <= w_cur_ptr;
                r_slot_ptr[w_m_idx][w_n_idx] <= w_ptr_inc;
            end
        end
    end

    assign o_wr_en     = r_wr_en;
    assign o_wr_slot   = r_wr_slot;
    assign o_wr_row    = r_wr_row;
    assign o_wr_col    = r_wr_col;
    assign o_wr_data   = r_wr_data;
    assign o_wr_commit = r_commit;
    assign o_done      = r_commit;
    assign o_error     = r_error;
    assign o_err_code  = r_err_code;
    assign o_dim_m     = r_dim_m;
    assign o_dim_n     = r_dim_n;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_matrix_input_sequencer.sv
// Self-checking bench: a token-counting reference model predicts every output each cycle,
// directed scenarios pin the model with literal values, then randomized sessions stress it.
module tb_matrix_input_sequencer;

    localparam int MAX_DIM    = 5;
    localparam int MAX_STORE  = 2;
    localparam int ELEM_WIDTH = 8;
    localparam int SLOT_W     = 1;

    logic                  clk;
    logic                  i_rst;
    logic                  i_start;
    logic                  i_abort;
    logic                  i_rx_valid;
    logic [7:0]            i_rx_data;
    logic                  o_wr_en;
    logic [SLOT_W-1:0]     o_wr_slot;
    logic [2:0]            o_wr_row;
    logic [2:0]            o_wr_col;
    logic [ELEM_WIDTH-1:0] o_wr_data;
    logic                  o_wr_commit;
    logic [2:0]            o_dim_m;
    logic [2:0]            o_dim_n;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_error;
    logic [1:0]            o_err_code;

    matrix_input_sequencer #(
        .MAX_DIM   (MAX_DIM),
        .MAX_STORE (MAX_STORE),
        .ELEM_WIDTH(ELEM_WIDTH)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_rx_valid (i_rx_valid),
        .i_rx_data  (i_rx_data),
        .o_wr_en    (o_wr_en),
        .o_wr_slot  (o_wr_slot),
        .o_wr_row   (o_wr_row),
        .o_wr_col   (o_wr_col),
        .o_wr_data  (o_wr_data),
        .o_wr_commit(o_wr_commit),
        .o_dim_m    (o_dim_m),
        .o_dim_n    (o_dim_n),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_error    (o_error),
        .o_err_code (o_err_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit is_sep(input logic [7:0] b);
        return (b == 8'h20) || (b == 8'h0D) || (b == 8'h0A);
    endfunction

    // Reference model: counts accepted digits since start; digit 0 is m, digit 1 is n,
    // digit k>=2 is element k-2 placed at (idx / n, idx % n).
    bit m_armed, m_pending;
    int m_k, m_m, m_n;
    int m_ptr [MAX_DIM][MAX_DIM];
    int e_wr_en, e_wr_slot, e_wr_row, e_wr_col, e_wr_data;
    int e_done, e_error, e_err_code, e_dim_m, e_dim_n, e_busy;

    task automatic model_step();
        int d, idx;
        if (i_rst) begin
            m_armed = 0; m_pending = 0; m_k = 0; m_m = 0; m_n = 0;
            for (int i = 0; i < MAX_DIM; i++)
                for (int j = 0; j < MAX_DIM; j++) m_ptr[i][j] = 0;
            e_wr_en = 0; e_wr_slot = 0; e_wr_row = 0; e_wr_col = 0; e_wr_data = 0;
            e_done = 0; e_error = 0; e_err_code = 0; e_dim_m = 0; e_dim_n = 0; e_busy = 0;
            return;
        end
        e_wr_en = 0; e_done = 0; e_error = 0;
        if (i_abort) begin
            m_armed = 0; m_pending = 0;
        end else if (m_pending) begin
            e_done    = 1;
            e_wr_slot = m_ptr[m_m-1][m_n-1];
            m_ptr[m_m-1][m_n-1] = (m_ptr[m_m-1][m_n-1] + 1) % MAX_STORE;
            m_pending = 0; m_armed = 0;
        end else if (!m_armed) begin
            if (i_start) begin
                m_armed = 1; m_k = 0; e_err_code = 0;
            end
        end else if (i_rx_valid && !is_sep(i_rx_data)) begin
            if (i_rx_data < 8'h30 || i_rx_data > 8'h39) begin
                e_error = 1; e_err_code = 1; m_armed = 0;
            end else begin
                d = int'(i_rx_data) - 48;
                if (m_k < 2) begin
                    if (d < 1 || d > MAX_DIM) begin
                        e_error = 1; e_err_code = 2; m_armed = 0;
                    end else if (m_k == 0) begin
                        m_m = d; e_dim_m = d; m_k++;
                    end else begin
                        m_n = d; e_dim_n = d; m_k++;
                    end
                end else begin
                    idx       = m_k - 2;
                    e_wr_en   = 1;
                    e_wr_row  = idx / m_n;
                    e_wr_col  = idx % m_n;
                    e_wr_data = d;
                    e_wr_slot = m_ptr[m_m-1][m_n-1];
                    m_k++;
                    if (idx == m_m * m_n - 1) m_pending = 1;
                end
            end
        end
        e_busy = (m_armed || m_pending) ? 1 : 0;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    typedef struct {
        int row;
        int col;
        int data;
        int cyc;
    } wr_rec_t;

    wr_rec_t wlog[$];
    bit      cmp_en = 0;
    int      cyc_cnt = 0;

    // Compare process: DUT outputs are sampled on the falling edge, clear of the active edge.
    initial forever begin
        @(negedge clk);
        cyc_cnt++;
        if (cmp_en) begin
            check("wr_en",     32'(o_wr_en),     32'(e_wr_en));
            check("done",      32'(o_done),      32'(e_done));
            check("wr_commit", 32'(o_wr_commit), 32'(e_done));
            check("error",     32'(o_error),     32'(e_error));
            check("err_code",  32'(o_err_code),  32'(e_err_code));
            check("busy",      32'(o_busy),      32'(e_busy));
            check("dim_m",     32'(o_dim_m),     32'(e_dim_m));
            check("dim_n",     32'(o_dim_n),     32'(e_dim_n));
            if (e_wr_en != 0 || e_done != 0)
                check("wr_slot", 32'(o_wr_slot), 32'(e_wr_slot));
            if (e_wr_en != 0) begin
                check("wr_row",  32'(o_wr_row),  32'(e_wr_row));
                check("wr_col",  32'(o_wr_col),  32'(e_wr_col));
                check("wr_data", 32'(o_wr_data), 32'(e_wr_data));
            end
        end
        if (o_wr_en) wlog.push_back('{int'(o_wr_row), int'(o_wr_col), int'(o_wr_data), cyc_cnt});
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            i_rx_valid = 1'b1;
            i_rx_data  = s[i];
            @(negedge clk);
            i_rx_valid = 1'b0;
            if (i != s.len() - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_done(input string name, output int slot);
        bit got = 0;
        slot = -1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (o_done) begin
                got  = 1;
                slot = int'(o_wr_slot);
            end
        end
        check({name, "_done_seen"}, 32'(got), 32'd1);
    endtask

    task automatic run_good(input string name, input string s, input int exp_slot);
        int slot;
        pulse_start();
        send_str(s, 1);
        wait_done(name, slot);
        check({name, "_slot"}, 32'(slot), 32'(exp_slot));
        @(negedge clk);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    int exp_row [6] = '{0, 0, 0, 1, 1, 1};
    int exp_col [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        int base;
        logic [7:0] bq[$];
        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        cmp_en = 1;

        // Reset state.
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_wr_en", 32'(o_wr_en), 32'd0);
        check("rst_err_code", 32'(o_err_code), 32'd0);
        check("rst_dim_m", 32'(o_dim_m), 32'd0);
        check("rst_dim_n", 32'(o_dim_n), 32'd0);

        // First 2x3 matrix with literal expectations on writes and commit timing.
        wlog.delete();
        pulse_start();
        check("arm_busy", 32'(o_busy), 32'd1);
        send_str("2 3 1 2 3 4 5 6", 1);
        check("last_wr_en", 32'(o_wr_en), 32'd1);
        check("last_wr_data", 32'(o_wr_data), 32'd6);
        check("last_not_done", 32'(o_done), 32'd0);
        @(negedge clk);
        check("t1_done", 32'(o_done), 32'd1);
        check("t1_commit", 32'(o_wr_commit), 32'd1);
        check("t1_slot", 32'(o_wr_slot), 32'd0);
        check("t1_busy", 32'(o_busy), 32'd0);
        check("t1_dim_m", 32'(o_dim_m), 32'd2);
        check("t1_dim_n", 32'(o_dim_n), 32'd3);
        check("t1_nwrites", 32'(wlog.size()), 32'd6);
        for (int i = 0; i < 6 && i < wlog.size(); i++) begin
            check("t1_row", 32'(wlog[i].row), 32'(exp_row[i]));
            check("t1_col", 32'(wlog[i].col), 32'(exp_col[i]));
            check("t1_data", 32'(wlog[i].data), 32'(i + 1));
        end
        @(negedge clk);

        // Round-robin per shape: 2x3 -> 1, 3x3 -> 0 independently, 2x3 -> 0 (wrap).
        run_good("t2_a", "2 3 1 1 1 1 1 1", 1);
        run_good("t2_b", "3 3 9 8 7 6 5 4 3 2 1", 0);
        run_good("t2_c", "2 3 0 0 0 0 0 0", 0);

        // BAD_DIM on m too large and on zero.
        pulse_start();
        send_str("6", 0);
        check("dim6_error", 32'(o_error), 32'd1);
        check("dim6_code", 32'(o_err_code), 32'd2);
        check("dim6_busy", 32'(o_busy), 32'd0);
        pulse_start();
        check("restart_code_clr", 32'(o_err_code), 32'd0);
        send_str("0", 0);
        check("dim0_error", 32'(o_error), 32'd1);
        check("dim0_code", 32'(o_err_code), 32'd2);
        repeat (2) @(negedge clk);
        check("code_held", 32'(o_err_code), 32'd2);

        // BAD_CHAR after one element; the next good 2x2 reuses slot 0.
        wlog.delete();
        pulse_start();
        send_str("2 2 1 x", 1);
        check("badch_error", 32'(o_error), 32'd1);
        check("badch_code", 32'(o_err_code), 32'd1);
        check("badch_nwrites", 32'(wlog.size()), 32'd1);
        @(negedge clk);
        run_good("t5", "2 2 5 6 7 8", 0);

        // Abort mid-element, together with a byte and a start in the same cycle.
        pulse_start();
        send_str("2 2 9", 1);
        i_abort = 1'b1; i_start = 1'b1; i_rx_valid = 1'b1; i_rx_data = "9";
        @(negedge clk);
        i_abort = 1'b0; i_start = 1'b0; i_rx_valid = 1'b0;
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_wr_en", 32'(o_wr_en), 32'd0);
        check("abort_error", 32'(o_error), 32'd0);
        repeat (2) @(negedge clk);
        check("abort_no_done", 32'(o_done), 32'd0);
        run_good("t6", "2 2 1 1 1 1", 1);

        // Reset mid-matrix clears everything, including the pointer table.
        pulse_start();
        send_str("2 3 1 2", 1);
        do_reset();
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_dim_m", 32'(o_dim_m), 32'd0);
        run_good("t7_a", "2 3 1 2 3 4 5 6", 0);
        run_good("t7_b", "2 2 1 2 3 4", 0);

        // Four element digits on consecutive cycles.
        wlog.delete();
        pulse_start();
        send_str("2 2 ", 1);
        send_str("1234", 0);
        check("b2b_nwrites", 32'(wlog.size()), 32'd4);
        if (wlog.size() == 4) check("b2b_span", 32'(wlog[3].cyc - wlog[0].cyc), 32'd3);
        @(negedge clk);
        check("b2b_done", 32'(o_done), 32'd1);
        check("b2b_slot", 32'(o_wr_slot), 32'd1);
        @(negedge clk);

        // Start and a byte in the same cycle: the byte is dropped.
        i_start = 1'b1; i_rx_valid = 1'b1; i_rx_data = "3";
        @(negedge clk);
        i_start = 1'b0; i_rx_valid = 1'b0;
        send_str("2 2 4 3 2 1", 1);
        @(negedge clk);
        check("drop_done", 32'(o_done), 32'd1);
        check("drop_dim_m", 32'(o_dim_m), 32'd2);
        check("drop_slot", 32'(o_wr_slot), 32'd0);
        @(negedge clk);

        // Randomized sessions checked by the model every cycle.
        for (int s = 0; s < 250; s++) begin
            int m, n;
            bq.delete();
            m = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 9) : $urandom_range(1, MAX_DIM);
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 9) : $urandom_range(1, MAX_DIM);
            bq.push_back(8'(8'h30 + m));
            bq.push_back(8'(8'h30 + n));
            for (int e = 0; e < m * n; e++) bq.push_back(8'(8'h30 + $urandom_range(0, 9)));
            repeat ($urandom_range(0, 3)) bq.push_back(8'(8'h30 + $urandom_range(0, 9)));
            if (s % 4 == 0) begin
                i_start = 1'b1; i_rx_valid = 1'b1; i_rx_data = 8'(8'h30 + $urandom_range(0, 9));
                @(negedge clk);
                i_start = 1'b0; i_rx_valid = 1'b0;
            end else begin
                pulse_start();
            end
            foreach (bq[b]) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 15) begin
                    case ($urandom_range(0, 2))
                        0: i_rx_data = 8'h20;
                        1: i_rx_data = 8'h0D;
                        default: i_rx_data = 8'h0A;
                    endcase
                    i_rx_valid = 1'b1;
                    @(negedge clk);
                    i_rx_valid = 1'b0;
                end
                i_rx_data = bq[b];
                if (r == 20) i_rx_data = 8'h2F;
                if (r == 21) i_rx_data = 8'h3A;
                if (r == 22) i_rx_data = 8'(8'h41 + $urandom_range(0, 25));
                i_abort = (r == 30);
                i_start = (r >= 31 && r <= 33);
                i_rst   = (r == 40 && s % 3 == 0);
                i_rx_valid = 1'b1;
                @(negedge clk);
                i_rx_valid = 1'b0; i_abort = 1'b0; i_start = 1'b0; i_rst = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_input_sequencer.md
# matrix_input_sequencer

Byte-level controller sitting between the UART receiver and the matrix storage in the matrix calculator. While armed by the FSM in input mode it parses an ASCII stream "m n e00 e01 …", validates dimensions and digits, and drives row-major element writes into storage. It owns the per-dimension round-robin slot pointers that implement "overwrite oldest" for each m×n shape, and reports done/error back to the FSM.

## Interface
Parameters:
- MAX_DIM, 5, largest legal row/column count (1..MAX_DIM)
- MAX_STORE, 2, slots per m×n shape; SLOT_W = max(1, clog2(MAX_STORE))
- ELEM_WIDTH, 8, width of wr_data

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock domain, synchronous, active-high
- start  in  1  one-cycle pulse from the FSM that arms a new matrix input
- abort  in  1  FSM cancel (timeout/mode change); returns to IDLE with no commit
- rx_valid  in  1  one-cycle strobe; rx_data is valid
- rx_data  in  8  received byte
- wr_en  out  1  element write strobe to storage
- wr_slot  out  SLOT_W  target slot for this shape
- wr_row, wr_col  out  3 each  element coordinates, 0-based
- wr_data  out  ELEM_WIDTH  element value 0..9, zero-extended
- wr_commit  out  1  one-cycle pulse: the slot is complete and now valid
- dim_m, dim_n  out  3 each  dimensions of the matrix in progress or last completed
- busy  out  1  high from the accepted start until done, error, or abort
- done  out  1  one-cycle pulse, coincident with wr_commit
- error  out  1  one-cycle pulse on a parse/validation failure
- err_code  out  2  0 none, 1 BAD_CHAR, 2 BAD_DIM; held until the next start

## Operation
- Byte classes:
  - digit: 0x30–0x39, value = byte − 0x30.
  - separator: 0x20, 0x0D, 0x0A; ignored in every state.
  - anything else: BAD_CHAR.
- States: IDLE, GET_M, GET_N, GET_ELEM, COMMIT.
- IDLE:
  - start → GET_M; busy=1; err_code cleared; row/col counters cleared.
  - rx bytes are ignored in IDLE.
- GET_M:
  - digit d with 1 ≤ d ≤ MAX_DIM → latch dim_m, go to GET_N.
  - d = 0 or d > MAX_DIM → BAD_DIM.
- GET_N: same rule, latching dim_n, then go to GET_ELEM.
- GET_ELEM:
  - Each digit issues one write at (row, col) with the current slot pointer for (dim_m, dim_n).
  - col increments; at col = dim_n−1, col wraps to 0 and row increments.
  - After the write of (dim_m−1, dim_n−1) → COMMIT.
- COMMIT (one cycle):
  - Pulse wr_commit and done; wr_slot shows the committed slot.
  - Advance that shape's pointer modulo MAX_STORE (wraps MAX_STORE−1 → 0).
  - busy → 0; go to IDLE.
- Error (BAD_CHAR or BAD_DIM):
  - Pulse error, set err_code, busy → 0, go to IDLE.
  - No commit; the pointer is unchanged, so the partial slot is overwritten by the next success.
- Slot pointers: MAX_DIM×MAX_DIM entries, each SLOT_W bits, all 0 after reset.
- Writes beyond a complete matrix cannot occur: extra bytes arrive after return to IDLE and are dropped.

## Timing
- Reset values:
  - All outputs 0, err_code = 0, dim_m/dim_n = 0.
  - State IDLE; all slot pointers 0.
- Write latency: wr_en and its address/data are registered, one cycle after the rx_valid cycle. wr_en is a one-cycle pulse.
- COMMIT occurs the cycle after the last wr_en; done/wr_commit are therefore two cycles after the final byte's rx_valid.
- error pulses one cycle after the offending rx_valid.
- start while busy is ignored.
- start and rx_valid in the same cycle: the byte is dropped and the FSM is armed.
- abort has priority over rx_valid and start in the same cycle:
  - Next cycle IDLE, busy=0.
  - No wr_en, done, error, or commit.
  - err_code unchanged.
- rst mid-matrix: all state, including pointers, returns to reset values on the next edge.
- Back-to-back rx_valid on consecutive cycles must be accepted without loss.

## Test plan
- start; bytes "2 3 1 2 3 4 5 6" → six wr_en at (0,0)..(1,2) with data 1..6, slot 0; done+wr_commit two cycles after '6'; dim_m=2, dim_n=3.
- Repeat the same 2×3 input three times → slots 0, 1, 0 (wrap); a 3×3 matrix in between uses slot 0 independently.
- start; "6" → error one cycle later, err_code=2, no wr_en; then "0" after a fresh start → err_code=2.
- start; "2 2 1 x" → one wr_en, then error with err_code=1; the next good 2×2 reuses slot 0.
- Mid-element abort, and separately rst → no commit; busy=0 next cycle; after rst all pointers are 0.
- Four digits on consecutive clock cycles for a 2×2 → four consecutive wr_en, done after the last.
